// File: rtl/ofdm_symbol_framer.sv
// OFDM symbol framer: chops the raw sample stream into Avalon-ST symbol packets
// after a timing-sync pulse, with an Avalon-MM CSR port for length/count/status.
module ofdm_symbol_framer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic [1:0]        avs_cfg_address,
  input  logic              avs_cfg_write,
  input  logic [31:0]       avs_cfg_writedata,
  input  logic              avs_cfg_read,
  output logic [31:0]       avs_cfg_readdata,
  input  logic              sync_pulse,
  input  logic [DATA_W-1:0] asi_in0_data,
  input  logic              asi_in0_valid,
  output logic              asi_in0_ready,
  output logic [DATA_W-1:0] aso_out0_data,
  output logic              aso_out0_valid,
  input  logic              aso_out0_ready,
  output logic              aso_out0_startofpacket,
  output logic              aso_out0_endofpacket,
  output logic              frame_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_e;

  state_e              state_q, state_d;
  logic                enable_q, enable_d;
  logic [CNT_W-1:0]    sym_len_q, sym_len_d;
  logic [CNT_W-1:0]    num_sym_q, num_sym_d;
  logic [CNT_W-1:0]    len_sh_q, len_sh_d;
  logic [CNT_W-1:0]    num_sh_q, num_sh_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;

  logic                accept_c;
  logic                last_samp_c;
  logic                last_frame_c;
  logic                wdata_unused_c;

  // In RUN the input only stalls when the output register is full and blocked.
  assign asi_in0_ready = (state_q != S_RUN) | aso_out0_ready | ~out_valid_q;
  assign accept_c      = (state_q == S_RUN) & asi_in0_valid & asi_in0_ready;
  assign last_samp_c   = (sample_cnt_q == len_sh_q - CNT_W'(1));
  assign last_frame_c  = last_samp_c & (sym_cnt_q == num_sh_q - CNT_W'(1));
  assign wdata_unused_c = ^avs_cfg_writedata;

  assign avs_cfg_readdata       = rdata_q;
  assign aso_out0_data          = out_data_q;
  assign aso_out0_valid         = out_valid_q;
  assign aso_out0_startofpacket = out_sop_q;
  assign aso_out0_endofpacket   = out_eop_q;
  assign frame_busy             = (state_q == S_RUN);

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q      <= S_IDLE;
      enable_q     <= 1'b0;
      sym_len_q    <= CNT_W'(32);
      num_sym_q    <= CNT_W'(1);
      len_sh_q     <= CNT_W'(32);
      num_sh_q     <= CNT_W'(1);
      sample_cnt_q <= '0;
      sym_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      rdata_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      sym_len_q    <= sym_len_d;
      num_sym_q    <= num_sym_d;
      len_sh_q     <= len_sh_d;
      num_sh_q     <= num_sh_d;
      sample_cnt_q <= sample_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      rdata_q      <= rdata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    sym_len_d    = sym_len_q;
    num_sym_d    = num_sym_q;
    len_sh_d     = len_sh_q;
    num_sh_d     = num_sh_q;
    sample_cnt_d = sample_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
    rdata_d      = rdata_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;

    if (avs_cfg_write) begin
      case (avs_cfg_address)
        2'd0:    enable_d  = avs_cfg_writedata[0];
        2'd1:    sym_len_d = avs_cfg_writedata[CNT_W-1:0];
        2'd2:    num_sym_d = avs_cfg_writedata[CNT_W-1:0];
        default: if (avs_cfg_writedata[16]) overrun_d = 1'b0;
      endcase
    end
    // A new overrun wins over a simultaneous clear.
    if (state_q == S_RUN && sync_pulse) overrun_d = 1'b1;

    if (avs_cfg_read) begin
      case (avs_cfg_address)
        2'd0:    rdata_d = {31'd0, enable_q};
        2'd1:    rdata_d = 32'(sym_len_q);
        2'd2:    rdata_d = 32'(num_sym_q);
        default: rdata_d = {15'd0, overrun_q, 16'(frame_cnt_q)};
      endcase
    end

    if (aso_out0_ready) out_valid_d = 1'b0;
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_data_d  = asi_in0_data;
      out_sop_d   = (sample_cnt_q == '0);
      out_eop_d   = last_samp_c;
    end

    case (state_q)
      S_IDLE: begin
        if (enable_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (sync_pulse) begin
          state_d      = S_RUN;
          len_sh_d     = (sym_len_q < CNT_W'(2)) ? CNT_W'(2) : sym_len_q;
          num_sh_d     = (num_sym_q == '0) ? CNT_W'(1) : num_sym_q;
          sample_cnt_d = '0;
          sym_cnt_d    = '0;
        end else if (!enable_q) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          if (last_samp_c) begin
            sample_cnt_d = '0;
            sym_cnt_d    = sym_cnt_q + CNT_W'(1);
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
          if (last_frame_c) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = enable_q ? S_ARMED : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/ofdm_symbol_framer.md
# ofdm_symbol_framer

Controller that sequences the OFDM cyclic-prefix removal stage. It takes the raw, unframed 32-bit I/Q sample stream from the front end. On a timing-sync pulse it starts a frame and chops the stream into a programmed number of symbols. Each symbol is emitted as one Avalon-ST packet with startofpacket/endofpacket, so the downstream prefix-wipe stage receives correctly framed symbols. Symbol length and symbols-per-frame are set over a small Avalon-MM CSR port; the port also reports frame count and sync-overrun status.

## Interface
- DATA_W, 32, sample width (packed I/Q)
- CNT_W, 16, width of symbol-length, symbol-count and frame counters
- clock_clk  in  1  sole clock
- reset_reset  in  1  synchronous, active-high reset
- avs_cfg_address  in  2  CSR word address
- avs_cfg_write  in  1  CSR write strobe
- avs_cfg_writedata  in  32  CSR write data
- avs_cfg_read  in  1  CSR read strobe
- avs_cfg_readdata  out  32  CSR read data, valid 1 cycle after read
- sync_pulse  in  1  one-cycle frame-start indication from timing sync
- asi_in0_data  in  DATA_W  input sample
- asi_in0_valid  in  1  input sample valid
- asi_in0_ready  out  1  input ready
- aso_out0_data  out  DATA_W  output sample
- aso_out0_valid  out  1  output valid
- aso_out0_ready  in  1  downstream ready
- aso_out0_startofpacket  out  1  first sample of symbol
- aso_out0_endofpacket  out  1  last sample of symbol
- frame_busy  out  1  high while in RUN

## Operation
- CSR map:
  - 0 CTRL: bit0 enable, reset 0.
  - 1 SYM_LEN: samples per symbol, prefix plus FFT, [CNT_W-1:0]; reset 32.
  - 2 NUM_SYM: symbols per frame; reset 1.
  - 3 STATUS: [15:0] frames completed (RO, wraps); bit16 overrun (sticky; write 1 to clear). Reads of unused bits return 0.
- Config values are latched into shadow registers on the IDLE/ARMED→RUN transition. CSR writes during RUN update the CSRs only and take effect next frame.
- Clamping at latch: SYM_LEN<2 is treated as 2; NUM_SYM=0 is treated as 1.
- States: IDLE, ARMED, RUN.
  - IDLE: enable=0. asi_in0_ready=1 and samples are discarded. Go to ARMED when enable=1.
  - ARMED: asi_in0_ready=1 and samples are discarded. A sync_pulse latches config, clears sample_cnt/sym_cnt and moves to RUN. If enable=0, return to IDLE.
  - RUN: asi_in0_ready = aso_out0_ready | ~aso_out0_valid. An accepted sample (valid&ready) loads the output register:
    - startofpacket = (sample_cnt==0)
    - endofpacket = (sample_cnt==SYM_LEN-1)
    - sample_cnt increments and wraps to 0 after SYM_LEN-1; sym_cnt increments on that wrap.
  - Accepting the last sample of symbol NUM_SYM-1 increments the frame counter. The FSM then goes to ARMED if enable=1, else IDLE.
- Clearing enable mid-frame does not abort the frame; it takes effect at frame end.
- sync_pulse while in RUN is ignored for framing and sets STATUS.overrun.
- Counter arithmetic is unsigned, CNT_W wide; the frame counter wraps 0xFFFF→0.

## Timing
- Reset (sync): FSM=IDLE; all CSRs at the reset values above; counters=0.
  - aso_out0_valid/startofpacket/endofpacket=0, aso_out0_data=0, avs_cfg_readdata=0, frame_busy=0.
  - asi_in0_ready=1, combinational from state.
- Reset mid-frame drops the frame. Downstream sees valid fall with no endofpacket.
- Latency: 1 cycle from input accept to output valid. Full throughput of 1 sample/clock when aso_out0_ready=1.
- Output hold: aso_out0_valid stays high, with data/sop/eop stable, until aso_out0_ready=1. It falls the cycle after the hand-off if no new sample is accepted.
- sync_pulse in ARMED at cycle T: RUN starts at T+1. The sample accepted at T is discarded; the first accepted sample at ≥T+1 is symbol 0 sample 0.
- frame_busy=1 exactly while in RUN. The final output beat may remain pending in ARMED/IDLE and must still complete the handshake.
- Simultaneous sync_pulse and frame-final accept: frame ends, the pulse counts as overrun, and the FSM goes to ARMED (it does not re-arm on that pulse).
- CSR read: readdata is registered and valid the cycle after avs_cfg_read. Write and read in the same cycle to STATUS returns the pre-write value.

## Test plan
- Defaults: enable=1, then sync_pulse, then 32 continuous samples 0..31 → 32 output beats in order, sop on data 0, eop on data 31, STATUS[15:0]=1, FSM back in ARMED.
- SYM_LEN=10, NUM_SYM=3, sync, 40 samples → 3 packets of 10 (sop on sample 0/10/20, eop on sample 9/19/29); samples 30..39 are discarded.
- Backpressure: aso_out0_ready toggles every other cycle during a 32-sample symbol → no sample lost or duplicated, output stable while stalled, input ready low when the output is full and not ready.
- Overrun: sync_pulse at sample 5 of a frame → framing is unaffected and STATUS bit16=1. Writing 0x10000 to STATUS clears bit16.
- Reconfig and disable: write SYM_LEN=8 mid-frame, then clear enable → current frame completes with 32-sample symbols, then FSM=IDLE. Re-enabling and syncing gives 8-sample symbols.
- Edge config: SYM_LEN=0 and NUM_SYM=0 → one 2-sample packet per frame. Reset asserted mid-frame → all outputs zero and FSM=IDLE the next cycle.
